mpy_sequencer: RTL and testbench

MPY_SEQUENCER -- requirements
Module: mpy_sequencer

---
 rtl/mpy_pkg.sv | 20 ++
 rtl/mpy_sequencer_if.sv | 34 +++
 rtl/mpy_sequencer.sv | 90 +++++++++
 tb/tb_mpy_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mpy_pkg.sv
// Shared definitions for the MPY request sequencer and its multiplier link.
// Holds the operand, multiplier-port and product widths, the settle
// counter width, the smallest legal settle time and the FSM state type.
package mpy_pkg;

  localparam int OPND_W     = 16;
  localparam int MPORT_W    = 18;
  localparam int PROD_W     = 36;
  localparam int RES_W      = 32;
  localparam int CNT_W      = 5;
  localparam int SETTLE_MIN = 20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HI,
    ST_LO
  } mpy_state_e;

endpackage

// File: rtl/mpy_sequencer_if.sv
// Bundle of request, multiplier and result-stream signals for mpy_sequencer.
//   start/src_a/src_b : MPY request and operands
//   busy              : request in flight
//   mult_a/mult_b     : registered operands to the shift-add multiplier
//   mult_p            : product returned by the multiplier
//   word_out/word_valid/word_last/word_ready : two-word result stream
// slave  : the sequencer side
// master : the requester / multiplier / consumer side
interface mpy_sequencer_if ();
  import mpy_pkg::*;

  logic                 start;
  logic [OPND_W-1:0]    src_a;
  logic [OPND_W-1:0]    src_b;
  logic                 busy;
  logic [MPORT_W-1:0]   mult_a;
  logic [MPORT_W-1:0]   mult_b;
  logic [PROD_W-1:0]    mult_p;
  logic [OPND_W-1:0]    word_out;
  logic                 word_valid;
  logic                 word_last;
  logic                 word_ready;

  modport slave (
    input  start, src_a, src_b, mult_p, word_ready,
    output busy, mult_a, mult_b, word_out, word_valid, word_last
  );

  modport master (
    output start, src_a, src_b, mult_p, word_ready,
    input  busy, mult_a, mult_b, word_out, word_valid, word_last
  );

endinterface

// File: rtl/mpy_sequencer.sv
// MPY request sequencer: latches operands for an external shift-add
// multiplier, waits SETTLE_CYCLES edges for the product to settle, then
// hands the 32-bit product out as two 16-bit words (high first).
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : mpy_sequencer_if.slave (request, multiplier link, result stream)
// SETTLE_CYCLES must lie in [SETTLE_MIN, 32] to fit the 5-bit counter.
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_IDLE   | waiting for start; busy=0, no word presented
// ST_SETTLE | operands latched, counting edges until product valid
// ST_HI     | presenting result[31:16], waiting for word_ready
// ST_LO     | presenting result[15:0] with word_last, waiting ready
module mpy_sequencer
  import mpy_pkg::*;
#(
  parameter int SETTLE_CYCLES = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  mpy_sequencer_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  mpy_state_e         state;
  logic [CNT_W-1:0]   count;
  logic [RES_W-1:0]   result;

  // Guard bits of the 36-bit product are never consumed.
  logic unused_prod_hi;
  assign unused_prod_hi = ^bus.mult_p[PROD_W-1:RES_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      count          <= '0;
      result         <= '0;
      bus.busy       <= 1'b0;
      bus.word_valid <= 1'b0;
      bus.word_last  <= 1'b0;
      bus.word_out   <= '0;
      bus.mult_a     <= '0;
      bus.mult_b     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            bus.mult_a <= {2'b00, bus.src_a};
            bus.mult_b <= {2'b00, bus.src_b};
            count      <= '0;
            bus.busy   <= 1'b1;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          count <= count + 1'b1;
          if (count == CNT_LAST) begin
            // Present the high word straight from the product so it is
            // valid in the same cycle the result register is loaded.
            result         <= bus.mult_p[RES_W-1:0];
            bus.word_out   <= bus.mult_p[RES_W-1:OPND_W];
            bus.word_valid <= 1'b1;
            bus.word_last  <= 1'b0;
            state          <= ST_HI;
          end
        end
        ST_HI: begin
          if (bus.word_ready) begin
            bus.word_out  <= result[OPND_W-1:0];
            bus.word_last <= 1'b1;
            state         <= ST_LO;
          end
        end
        ST_LO: begin
          if (bus.word_ready) begin
            bus.word_out   <= '0;
            bus.word_valid <= 1'b0;
            bus.word_last  <= 1'b0;
            bus.busy       <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpy_sequencer.sv
// Self-checking bench for mpy_sequencer: directed corner cases plus random
// requests, compared against a plain-arithmetic product model.
module tb_mpy_sequencer;
  import mpy_pkg::*;

  logic clk;
  logic reset_n;
  logic [3:0] junk;
  int n_tests;
  int n_fail;

  mpy_sequencer_if bus ();

  mpy_sequencer #(.SETTLE_CYCLES(20)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Combinational multiplier stand-in; guard nibble is scrambled so the
  // sequencer must ignore it.
  logic [PROD_W-1:0] prod_full;
  assign prod_full  = PROD_W'(bus.mult_a) * PROD_W'(bus.mult_b);
  assign bus.mult_p = {prod_full[PROD_W-1:RES_W] ^ junk, prod_full[RES_W-1:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full request: accept, settle, HI word (with stalls), LO word (with
  // stalls). disturb injects ignored starts and operand changes.
  task automatic run_txn(input logic [15:0] a, input logic [15:0] b,
                         input int hi_stall, input int lo_stall, input bit disturb);
    logic [31:0] exp;
    int k;
    bit seen;
    exp  = 32'(a) * 32'(b);
    junk = 4'($urandom);
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("idle_valid", bus.word_valid, 0);
    bus.src_a = a;
    bus.src_b = b;
    bus.start = 1'b1;
    bus.word_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk("accept_busy", bus.busy, 1);
    chk("mult_a_load", bus.mult_a, {2'b00, a});
    chk("mult_b_load", bus.mult_b, {2'b00, b});
    k = 0;
    seen = 0;
    while (k < 60 && !seen) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (disturb) begin
        if (k == 5) begin
          bus.start = 1'b1;
          bus.src_a = ~a;
          bus.src_b = ~b;
        end
        if (k == 6) bus.start = 1'b0;
        if (k == 8) bus.src_a = a ^ 16'h5A5A;
      end
      if (bus.word_valid) seen = 1;
    end
    chk("latency", 36'(k), 20);
    if (!seen) return;
    chk("hi_word", bus.word_out, exp[31:16]);
    chk("hi_last", bus.word_last, 0);
    chk("hi_busy", bus.busy, 1);
    for (int i = 0; i < hi_stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hi_stall_word", bus.word_out, exp[31:16]);
      chk("hi_stall_last", bus.word_last, 0);
      chk("hi_stall_valid", bus.word_valid, 1);
      chk("hi_stall_busy", bus.busy, 1);
    end
    bus.word_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.word_ready = 1'b0;
    chk("lo_word", bus.word_out, exp[15:0]);
    chk("lo_last", bus.word_last, 1);
    chk("lo_valid", bus.word_valid, 1);
    for (int i = 0; i < lo_stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("lo_stall_word", bus.word_out, exp[15:0]);
      chk("lo_stall_last", bus.word_last, 1);
      chk("lo_stall_busy", bus.busy, 1);
    end
    bus.word_ready = 1'b1;
    if (disturb) begin
      bus.start = 1'b1;
      bus.src_a = ~a;
      bus.src_b = ~b;
    end
    @(posedge clk);
    @(negedge clk);
    bus.word_ready = 1'b0;
    bus.start = 1'b0;
    chk("done_busy", bus.busy, 0);
    chk("done_valid", bus.word_valid, 0);
    chk("done_last", bus.word_last, 0);
    chk("hold_mult_a", bus.mult_a, {2'b00, a});
    chk("hold_mult_b", bus.mult_b, {2'b00, b});
  endtask

  initial begin
    bit stale;
    n_tests = 0;
    n_fail = 0;
    junk = 4'h0;
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.word_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.word_valid, 0);
    chk("rst_last", bus.word_last, 0);
    chk("rst_word", bus.word_out, 0);
    chk("rst_mult_a", bus.mult_a, 0);
    chk("rst_mult_b", bus.mult_b, 0);
    reset_n = 1'b1;

    run_txn(16'h1234, 16'h5678, 0, 0, 0);
    run_txn(16'hFFFF, 16'hFFFF, 0, 0, 0);
    run_txn(16'h0000, 16'hABCD, 0, 0, 0);
    run_txn(16'hBEEF, 16'h1357, 7, 3, 0);
    run_txn(16'h4321, 16'h8765, 1, 1, 1);

    // Abort mid-settle with counter at 10.
    @(negedge clk);
    bus.src_a = 16'h1234;
    bus.src_b = 16'h5678;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_valid", bus.word_valid, 0);
    chk("abort_word", bus.word_out, 0);
    chk("abort_mult_a", bus.mult_a, 0);
    chk("abort_mult_b", bus.mult_b, 0);
    @(negedge clk);
    reset_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.word_valid || bus.busy) stale = 1;
    end
    chk("abort_no_stale", stale, 0);
    run_txn(16'h0003, 16'h0005, 0, 0, 0);

    run_txn(16'h0100, 16'h0100, 0, 0, 0);
    run_txn(16'h0100, 16'h0100, 0, 0, 0);

    for (int t = 0; t < 8; t++) begin
      run_txn(16'($urandom), 16'($urandom), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
